// File: rtl/ram_dma_copier.sv
// Word-granular forward copy/fill engine driving one port of a byte-addressed RAM
// with 1-cycle registered read data. Every output comes straight from a flop.
module ram_dma_copier #(
    parameter int MEM_WIDTH = 65536,
    parameter int LEN_W     = 16,
    localparam int ADDR_W   = $clog2(MEM_WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dst_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       pattern_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [LEN_W-1:0]  words_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);
    localparam int RW = ADDR_W + LEN_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    state_t             state, state_n;
    logic               mode_q, mode_n;
    logic [ADDR_W-1:0]  src_q, src_n, dst_q, dst_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [31:0]        pat_q, pat_n;
    logic               busy_n, done_n, error_n, en_n;
    logic [3:0]         we_n;
    logic [LEN_W-1:0]   words_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [31:0]        data_n;
    logic               bad_cmd;
    logic [RW-1:0]      span, dst_end, src_end;

    // Range ends computed wide enough that they can never wrap.
    assign span    = RW'({len_i, 2'b00});
    assign dst_end = RW'(dst_i) + span;
    assign src_end = RW'(src_i) + span;
    assign bad_cmd = (dst_i[1:0] != 2'b00) || (len_i == '0) || (dst_end > RW'(MEM_WIDTH)) ||
                     (!mode_i && ((src_i[1:0] != 2'b00) || (src_end > RW'(MEM_WIDTH))));

    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        src_n   = src_q;
        dst_n   = dst_q;
        len_n   = len_q;
        pat_n   = pat_q;
        busy_n  = busy_o;
        done_n  = 1'b0;
        error_n = error_o;
        words_n = words_o;
        en_n    = 1'b0;
        we_n    = 4'h0;
        addr_n  = mem_addr_o;
        data_n  = mem_data_o;
        case (state)
            S_IDLE: begin
                busy_n = 1'b0;
                if (start_i) begin
                    mode_n  = mode_i;
                    len_n   = len_i;
                    pat_n   = pattern_i;
                    words_n = '0;
                    error_n = 1'b0;
                    if (bad_cmd) begin
                        error_n = 1'b1;
                        done_n  = 1'b1;
                        state_n = S_DONE;
                    end else if (!mode_i) begin
                        busy_n  = 1'b1;
                        en_n    = 1'b1;
                        addr_n  = src_i;
                        src_n   = src_i + ADDR_W'(4);
                        dst_n   = dst_i;
                        state_n = S_RD;
                    end else begin
                        busy_n  = 1'b1;
                        en_n    = 1'b1;
                        we_n    = 4'hF;
                        addr_n  = dst_i;
                        data_n  = pattern_i;
                        dst_n   = dst_i + ADDR_W'(4);
                        state_n = S_WR;
                    end
                end
            end
            S_RD: state_n = S_CAP;
            S_CAP: begin
                en_n    = 1'b1;
                we_n    = 4'hF;
                addr_n  = dst_q;
                data_n  = mem_data_i;
                dst_n   = dst_q + ADDR_W'(4);
                state_n = S_WR;
            end
            S_WR: begin
                // The write on the bus commits at this edge whether or not we stop.
                words_n = words_o + LEN_W'(1);
                if (words_n != len_q && !abort_i) begin
                    en_n = 1'b1;
                    if (!mode_q) begin
                        addr_n  = src_q;
                        src_n   = src_q + ADDR_W'(4);
                        state_n = S_RD;
                    end else begin
                        we_n    = 4'hF;
                        addr_n  = dst_q;
                        data_n  = pat_q;
                        dst_n   = dst_q + ADDR_W'(4);
                        state_n = S_WR;
                    end
                end else begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort overrides any RD/CAP/WR progression above.
        if (abort_i && (state == S_RD || state == S_CAP || state == S_WR)) begin
            en_n    = 1'b0;
            we_n    = 4'h0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            error_n = 1'b1;
            state_n = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            mode_q     <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            pat_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            words_o    <= '0;
            mem_en_o   <= 1'b0;
            mem_we_o   <= 4'h0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            state      <= state_n;
            mode_q     <= mode_n;
            src_q      <= src_n;
            dst_q      <= dst_n;
            len_q      <= len_n;
            pat_q      <= pat_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            error_o    <= error_n;
            words_o    <= words_n;
            mem_en_o   <= en_n;
            mem_we_o   <= we_n;
            mem_addr_o <= addr_n;
            mem_data_o <= data_n;
        end
    end
endmodule

// File: tb/tb_ram_dma_copier.sv
// Directed bench for ram_dma_copier with a behavioural 1-cycle-latency RAM model.
module tb_ram_dma_copier;
    localparam int ADDR_W = 16;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start_i = 1'b0, mode_i = 1'b0, abort_i = 1'b0;
    logic [ADDR_W-1:0] src_i = '0, dst_i = '0;
    logic [LEN_W-1:0]  len_i = '0;
    logic [31:0]       pattern_i = '0;
    logic              busy_o, done_o, error_o, mem_en_o;
    logic [LEN_W-1:0]  words_o;
    logic [3:0]        mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [31:0]       mem_data_i = '0;

    logic [31:0] ram [16384];

    int checks = 0, failures = 0;
    int done_cyc, en_cnt, wr_cnt, bad_we;
    int wr_cyc [16];
    int wr_adr [16];

    ram_dma_copier dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .mode_i(mode_i), .src_i(src_i),
        .dst_i(dst_i), .len_i(len_i), .pattern_i(pattern_i), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .words_o(words_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) ram[mem_addr_o[ADDR_W-1:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
            mem_data_i <= ram[mem_addr_o[ADDR_W-1:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one command and watch the bus cycle by cycle (cycle 1 = first after E0).
    task automatic run_cmd(input logic md, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] len, input logic [31:0] pat,
                           input int abort_wr, input int pulse_at);
        done_cyc = -1; en_cnt = 0; wr_cnt = 0; bad_we = 0;
        mode_i = md; src_i = src; dst_i = dst; len_i = len; pattern_i = pat;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            abort_i = 1'b0;
            start_i = (c == pulse_at);
            if (mem_en_o) en_cnt++;
            if (mem_we_o != 4'h0 && mem_we_o != 4'hF) bad_we++;
            if (mem_en_o && mem_we_o != 4'h0) begin
                if (wr_cnt < 16) begin
                    wr_cyc[wr_cnt] = c;
                    wr_adr[wr_cnt] = int'(mem_addr_o);
                end
                wr_cnt++;
                if (wr_cnt == abort_wr) abort_i = 1'b1;
            end
            if (done_o) begin
                done_cyc = c;
                break;
            end
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        ram[16'h40] = 32'h11111111;
        ram[16'h41] = 32'h22222222;
        ram[16'h42] = 32'h33333333;
        #12;
        chk("rst_ctl", {busy_o, done_o, error_o, mem_en_o, mem_we_o, words_o, mem_addr_o}, 64'h0);
        chk("rst_data", mem_data_o, 64'h0);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);

        // 1: copy 3 words 0x100 -> 0x200
        run_cmd(1'b0, 16'h100, 16'h200, 16'd3, 32'h0, 0, 0);
        chk("t1_done_cyc", done_cyc, 10);
        chk("t1_words", words_o, 3);
        chk("t1_err", error_o, 0);
        chk("t1_we_legal", bad_we, 0);
        chk("t1_m0", ram[16'h80], 32'h11111111);
        chk("t1_m1", ram[16'h81], 32'h22222222);
        chk("t1_m2", ram[16'h82], 32'h33333333);
        chk("t1_busy_after", busy_o, 0);

        // 2: fill 4 words at 0x40
        run_cmd(1'b1, 16'h0, 16'h40, 16'd4, 32'hDEADBEEF, 0, 0);
        chk("t2_done_cyc", done_cyc, 5);
        chk("t2_wr_cnt", wr_cnt, 4);
        chk("t2_wr_cycles", {wr_cyc[0][7:0], wr_cyc[1][7:0], wr_cyc[2][7:0], wr_cyc[3][7:0]}, 32'h01020304);
        chk("t2_wr_addrs", {wr_adr[0][15:0], wr_adr[1][15:0], wr_adr[2][15:0], wr_adr[3][15:0]},
            64'h0040_0044_0048_004C);
        chk("t2_m_first", ram[16'h10], 32'hDEADBEEF);
        chk("t2_m_last", ram[16'h13], 32'hDEADBEEF);
        chk("t2_m_beyond", ram[16'h14], 32'h0);

        // 3: misaligned source rejected
        run_cmd(1'b0, 16'h102, 16'h200, 16'd1, 32'h0, 0, 0);
        chk("t3_done_cyc", done_cyc, 1);
        chk("t3_err", error_o, 1);
        chk("t3_en_cnt", en_cnt, 0);
        chk("t3_words", words_o, 0);

        // 4: fill touching the top of memory
        run_cmd(1'b1, 16'h0, 16'hFFFC, 16'd2, 32'hA5A5A5A5, 0, 0);
        chk("t4_err", error_o, 1);
        chk("t4_en_cnt", en_cnt, 0);
        chk("t4_done_cyc", done_cyc, 1);
        run_cmd(1'b1, 16'h0, 16'hFFFC, 16'd1, 32'hA5A5A5A5, 0, 0);
        chk("t4b_err", error_o, 0);
        chk("t4b_wr_cnt", wr_cnt, 1);
        chk("t4b_addr", wr_adr[0], 32'hFFFC);
        chk("t4b_words", words_o, 1);
        chk("t4b_done_cyc", done_cyc, 2);
        chk("t4b_mem", ram[16'h3FFF], 32'hA5A5A5A5);

        // 5: copy 8 words, abort while the 2nd write is on the bus
        run_cmd(1'b0, 16'h100, 16'h300, 16'd8, 32'h0, 2, 0);
        chk("t5_done_cyc", done_cyc, 7);
        chk("t5_words", words_o, 2);
        chk("t5_err", error_o, 1);
        chk("t5_en_cnt", en_cnt, 4);
        chk("t5_m1", ram[16'hC1], 32'h22222222);
        chk("t5_m2", ram[16'hC2], 32'h0);
        run_cmd(1'b1, 16'h0, 16'h400, 16'd1, 32'h12345678, 0, 0);
        chk("t5b_err", error_o, 0);
        chk("t5b_done_cyc", done_cyc, 2);
        chk("t5b_mem", ram[16'h100], 32'h12345678);

        // 6: start pulsed mid-fill is ignored
        run_cmd(1'b1, 16'h0, 16'h500, 16'd10, 32'hCAFEF00D, 0, 3);
        chk("t6_done_cyc", done_cyc, 11);
        chk("t6_words", words_o, 10);
        chk("t6_wr_cnt", wr_cnt, 10);

        // 6b: asynchronous reset in the middle of a fill
        mode_i = 1'b1; dst_i = 16'h600; len_i = 16'd10; pattern_i = 32'h77777777;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6b_busy_pre", busy_o, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6b_rst_ctl", {busy_o, done_o, error_o, mem_en_o, mem_we_o, words_o, mem_addr_o}, 64'h0);
        chk("t6b_rst_data", mem_data_o, 64'h0);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6b_idle", {busy_o, mem_en_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
